// File: rtl/lite_regbank_irq.sv
// Xillybus Lite slave: byte-strobed RAM region plus control region (ID, W1C IRQ status, enable,
// pending) driving a registered user_irq. Define LITE_TIMESTAMP_EN to add a timestamp counter.
module lite_regbank_irq #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_IRQ  = 4,
  parameter logic [31:0] ID_VALUE = 32'h4C52_0001
) (
  input  logic               user_clk,
  input  logic               rst_n,
  input  logic [31:0]        user_addr,
  input  logic               user_wren,
  input  logic [3:0]         user_wstrb,
  input  logic [31:0]        user_wr_data,
  input  logic               user_rden,
  output logic [31:0]        user_rd_data,
  output logic               user_irq,
  input  logic [NUM_IRQ-1:0] irq_src
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [2:0] OffId      = 3'd0;
  localparam logic [2:0] OffStatus  = 3'd1;
  localparam logic [2:0] OffEnable  = 3'd2;
  localparam logic [2:0] OffPending = 3'd3;
  localparam logic [2:0] OffTstamp  = 3'd4;

  logic [31:0]        r_ram [Depth];
  logic [31:0]        r_rd_data;
  logic               r_irq;
  logic [NUM_IRQ-1:0] r_irq_status;
  logic [NUM_IRQ-1:0] r_irq_enable;
  logic [NUM_IRQ-1:0] r_irq_src_d;

  logic               w_ctl_sel;
  logic [ADDR_W-1:0]  w_ram_idx;
  logic [2:0]         w_ctl_off;
  logic               w_ram_wr;
  logic               w_ctl_wr;
  logic [31:0]        w_mask;
  logic [NUM_IRQ-1:0] w_wdata_irq;
  logic [NUM_IRQ-1:0] w_status_clr;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_status_d;
  logic [NUM_IRQ-1:0] w_enable_d;
  logic [31:0]        w_rd_mux;
  logic               w_unused;

  assign w_ctl_sel = user_addr[ADDR_W+2];
  assign w_ram_idx = user_addr[ADDR_W+1:2];
  assign w_ctl_off = user_addr[4:2];
  assign w_ram_wr  = user_wren & ~w_ctl_sel;
  assign w_ctl_wr  = user_wren & w_ctl_sel;
  assign w_mask    = {{8{user_wstrb[3]}}, {8{user_wstrb[2]}},
                      {8{user_wstrb[1]}}, {8{user_wstrb[0]}}};

  // Upper address bits alias the map and are intentionally ignored.
  assign w_unused = ^{user_addr[31:ADDR_W+3], user_addr[1:0]};

  assign w_wdata_irq  = user_wr_data[NUM_IRQ-1:0] & w_mask[NUM_IRQ-1:0];
  assign w_status_clr = (w_ctl_wr && (w_ctl_off == OffStatus)) ? w_wdata_irq : '0;
  assign w_rise       = irq_src & ~r_irq_src_d;
  // OR-ing the rise after the clear makes a simultaneous event win over W1C.
  assign w_status_d   = (r_irq_status & ~w_status_clr) | w_rise;
  assign w_enable_d   = (w_ctl_wr && (w_ctl_off == OffEnable)) ?
                        ((r_irq_enable & ~w_mask[NUM_IRQ-1:0]) | w_wdata_irq) : r_irq_enable;

`ifdef LITE_TIMESTAMP_EN
  logic [31:0] r_tstamp;

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tstamp <= '0;
    end else if (w_ctl_wr && (w_ctl_off == OffTstamp) && (user_wstrb == 4'hF)) begin
      r_tstamp <= '0;
    end else begin
      r_tstamp <= r_tstamp + 32'd1;
    end
  end
`endif

  // RAM has no reset so it can map onto block RAM.
  always_ff @(posedge user_clk) begin
    if (w_ram_wr) begin
      r_ram[w_ram_idx] <= (r_ram[w_ram_idx] & ~w_mask) | (user_wr_data & w_mask);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (!w_ctl_sel) begin
      w_rd_mux = r_ram[w_ram_idx];
    end else begin
      case (w_ctl_off)
        OffId:      w_rd_mux = ID_VALUE;
        OffStatus:  w_rd_mux = 32'(r_irq_status);
        OffEnable:  w_rd_mux = 32'(r_irq_enable);
        OffPending: w_rd_mux = 32'(r_irq_status & r_irq_enable);
`ifdef LITE_TIMESTAMP_EN
        OffTstamp:  w_rd_mux = r_tstamp;
`endif
        default:    w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data    <= '0;
      r_irq        <= 1'b0;
      r_irq_status <= '0;
      r_irq_enable <= '0;
      r_irq_src_d  <= '0;
    end else begin
      if (user_rden) begin
        r_rd_data <= w_rd_mux;
      end
      r_irq        <= |(r_irq_status & r_irq_enable);
      r_irq_status <= w_status_d;
      r_irq_enable <= w_enable_d;
      r_irq_src_d  <= irq_src;
    end
  end

  assign user_rd_data = r_rd_data;
  assign user_irq     = r_irq;

endmodule

// File: tb/tb_lite_regbank_irq.sv
// Directed bench for lite_regbank_irq: vector table of bus accesses plus hand-written
// sequences for IRQ timing, W1C collision, async reset and (LITE_TIMESTAMP_EN) the counter.
module tb_lite_regbank_irq;

  localparam int unsigned NumIrq = 4;
  localparam logic [31:0] Ctl    = 32'h80;

  logic              user_clk;
  logic              rst_n;
  logic [31:0]       user_addr;
  logic              user_wren;
  logic [3:0]        user_wstrb;
  logic [31:0]       user_wr_data;
  logic              user_rden;
  logic [31:0]       user_rd_data;
  logic              user_irq;
  logic [NumIrq-1:0] irq_src;

  int n_checks;
  int n_fails;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  lite_regbank_irq #(
    .ADDR_W  (5),
    .NUM_IRQ (NumIrq),
    .ID_VALUE(32'h4C52_0001)
  ) dut (
    .user_clk    (user_clk),
    .rst_n       (rst_n),
    .user_addr   (user_addr),
    .user_wren   (user_wren),
    .user_wstrb  (user_wstrb),
    .user_wr_data(user_wr_data),
    .user_rden   (user_rden),
    .user_rd_data(user_rd_data),
    .user_irq    (user_irq),
    .irq_src     (irq_src)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] data);
    @(negedge user_clk);
    user_addr    = addr;
    user_wstrb   = strb;
    user_wr_data = data;
    user_wren    = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    user_wren = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge user_clk);
    user_addr = addr;
    user_rden = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    user_rden = 1'b0;
    data = user_rd_data;
  endtask

  task automatic add(input bit is_wr, input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] data, input logic [31:0] exp);
    vec_t v;
    v.is_wr = is_wr;
    v.addr  = addr;
    v.strb  = strb;
    v.data  = data;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] ts0;
    logic [31:0] ts1;
    n_checks     = 0;
    n_fails      = 0;
    rst_n        = 1'b0;
    user_addr    = '0;
    user_wren    = 1'b0;
    user_wstrb   = '0;
    user_wr_data = '0;
    user_rden    = 1'b0;
    irq_src      = '0;

    // Table: 1 = write, 0 = read-and-compare.
    add(1, 32'h0C, 4'hF, 32'hDDCC_BBAA, 0);
    add(1, 32'h0C, 4'b0101, 32'h1122_3344, 0);
    add(0, 32'h0C, 0, 0, 32'hDD22_BB44);
    add(0, 32'h10C, 0, 0, 32'hDD22_BB44);          // bit 8 ignored: alias
    add(1, 32'h7C, 4'hF, 32'h1234_5678, 0);
    add(0, 32'h7C, 0, 0, 32'h1234_5678);
    add(0, Ctl + 0, 0, 0, 32'h4C52_0001);
    add(1, Ctl + 0, 4'hF, 32'h0, 0);
    add(0, Ctl + 0, 0, 0, 32'h4C52_0001);
    add(0, Ctl + 20, 0, 0, 32'h0);
    add(0, Ctl + 24, 0, 0, 32'h0);
    add(1, Ctl + 28, 4'hF, 32'hFFFF_FFFF, 0);
    add(0, Ctl + 28, 0, 0, 32'h0);
    add(1, Ctl + 8, 4'hF, 32'hFFFF_FFFF, 0);
    add(0, Ctl + 8, 0, 0, 32'h0000_000F);          // only NUM_IRQ bits stick
    add(1, Ctl + 8, 4'b1110, 32'h0, 0);
    add(0, Ctl + 8, 0, 0, 32'h0000_000F);          // byte 0 not strobed
    add(1, Ctl + 8, 4'b0001, 32'h5, 0);
    add(0, Ctl + 8, 0, 0, 32'h0000_0005);
`ifndef LITE_TIMESTAMP_EN
    add(1, Ctl + 16, 4'hF, 32'h1234, 0);
    add(0, Ctl + 16, 0, 0, 32'h0);
`endif

    repeat (3) @(negedge user_clk);
    check("reset_rd_data", user_rd_data, 32'h0);
    check("reset_irq", {31'h0, user_irq}, 32'h0);
    rst_n = 1'b1;
    bus_read(Ctl + 4, rd);  check("reset_status", rd, 32'h0);
    bus_read(Ctl + 8, rd);  check("reset_enable", rd, 32'h0);
    bus_read(Ctl + 12, rd); check("reset_pending", rd, 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].addr, vecs[i].strb, vecs[i].data);
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d_addr%0h", i, vecs[i].addr), rd, vecs[i].exp);
      end
    end

    // Read data holds while rden is low, even if the RAM word changes.
    bus_read(32'h0C, rd);
    bus_write(32'h0C, 4'hF, 32'h0BAD_0BAD);
    repeat (2) @(negedge user_clk);
    check("rd_hold", user_rd_data, 32'hDD22_BB44);

    // Same-cycle write and read of one RAM word returns the old data.
    @(negedge user_clk);
    user_addr    = 32'h0C;
    user_wstrb   = 4'hF;
    user_wr_data = 32'hCAFE_F00D;
    user_wren    = 1'b1;
    user_rden    = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    user_wren = 1'b0;
    user_rden = 1'b0;
    check("rw_same_old", user_rd_data, 32'h0BAD_0BAD);
    bus_read(32'h0C, rd); check("rw_same_new", rd, 32'hCAFE_F00D);

    // Event and interrupt with IRQ_ENABLE = 0x5.
    @(negedge user_clk);
    irq_src[0] = 1'b1;
    @(negedge user_clk);
    check("irq_lat0", {31'h0, user_irq}, 32'h0);
    @(negedge user_clk);
    check("irq_lat1", {31'h0, user_irq}, 32'h1);
    @(negedge user_clk);
    irq_src[0] = 1'b0;
    bus_read(Ctl + 4, rd); check("status_after_pulse", rd, 32'h1);
    bus_write(Ctl + 4, 4'hF, 32'h1);
    check("irq_clear_lag", {31'h0, user_irq}, 32'h1);
    @(negedge user_clk);
    check("irq_cleared", {31'h0, user_irq}, 32'h0);
    bus_read(Ctl + 4, rd); check("status_cleared", rd, 32'h0);

    // Masking: status is set, irq stays low, pending reads 0.
    bus_write(Ctl + 8, 4'hF, 32'h0);
    @(negedge user_clk);
    irq_src[1] = 1'b1;
    repeat (3) @(negedge user_clk);
    check("masked_irq", {31'h0, user_irq}, 32'h0);
    bus_read(Ctl + 4, rd);  check("masked_status", rd, 32'h2);
    bus_read(Ctl + 12, rd); check("masked_pending", rd, 32'h0);

    // Rise on bit 2 in the same cycle as a W1C of bit 2: set wins.
    @(negedge user_clk);
    user_addr    = Ctl + 4;
    user_wstrb   = 4'hF;
    user_wr_data = 32'h4;
    user_wren    = 1'b1;
    irq_src[2]   = 1'b1;
    @(posedge user_clk);
    @(negedge user_clk);
    user_wren = 1'b0;
    bus_read(Ctl + 4, rd); check("collision_set_wins", rd, 32'h6);
    bus_write(Ctl + 4, 4'b1110, 32'h2);
    bus_read(Ctl + 4, rd); check("w1c_no_strobe", rd, 32'h6);
    bus_write(Ctl + 4, 4'b0001, 32'h2);
    bus_read(Ctl + 4, rd); check("w1c_bit1", rd, 32'h4);
    irq_src = '0;

    // Async reset with irq high and a read in flight.
    bus_write(Ctl + 8, 4'hF, 32'h4);
    bus_read(Ctl + 12, rd); check("pending_bit2", rd, 32'h4);
    bus_read(Ctl + 0, rd);
    check("pre_reset_irq", {31'h0, user_irq}, 32'h1);
    @(negedge user_clk);
    user_addr = 32'h0C;
    user_rden = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_data", user_rd_data, 32'h0);
    check("async_irq", {31'h0, user_irq}, 32'h0);
    @(negedge user_clk);
    user_rden = 1'b0;
    check("reset_rd_held", user_rd_data, 32'h0);
    @(negedge user_clk);
    rst_n = 1'b1;
    bus_read(Ctl + 4, rd); check("post_reset_status", rd, 32'h0);
    bus_read(Ctl + 8, rd); check("post_reset_enable", rd, 32'h0);

`ifdef LITE_TIMESTAMP_EN
    bus_write(Ctl + 16, 4'hF, 32'hFFFF_FFFF);
    repeat (100) @(posedge user_clk);
    bus_read(Ctl + 16, ts0);
    check("ts_in_range", {31'h0, (ts0 >= 32'd100) && (ts0 <= 32'd102)}, 32'h1);
    bus_write(Ctl + 16, 4'b0111, 32'h0);
    bus_read(Ctl + 16, ts1);
    check("ts_partial_ignored", {31'h0, ts1 > ts0 + 32'd2}, 32'h1);
`else
    ts0 = '0;
    ts1 = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
